led_breather: RTL and testbench



---
 rtl/led_pkg.sv | 12 +
 rtl/led_breather_pwm_core.sv | 32 +++
 rtl/led_breather.sv | 109 ++++++++++
 tb/tb_led_breather.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared phase encoding for the LED breathing controller.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HI   = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LO   = 3'd4
  } phase_e;

endpackage

// File: rtl/led_breather_pwm_core.sv
// Free-running PWM counter with end-of-period tick and registered LED comparator.
module pwm_core #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                clear,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led_out,
  output logic                period_tick
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;

  // A disable request restarts the period so re-enable always begins at count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_out <= 1'b0;
    end else begin
      if (run && !clear) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      else               pwm_cnt <= '0;
      led_out <= run && (pwm_cnt < duty);
    end
  end

  assign period_tick = run && (pwm_cnt == CNT_MAX);

endmodule

// File: rtl/led_breather.sv
// Breathing LED sequencer: ramps PWM duty up, holds, ramps down, holds, repeats.
module led_breather
  import led_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 32,
  parameter int HOLD_PERIODS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                led_out,
  output logic [2:0]          phase,
  output logic [PWM_BITS-1:0] duty,
  output logic                period_tick
);

  generate
    if (PWM_BITS < 2 || STEP_PERIODS < 1 || HOLD_PERIODS < 1) begin : g_bad_params
      $error("led_breather: need PWM_BITS>=2, STEP_PERIODS>=1, HOLD_PERIODS>=1");
    end
  endgenerate

  localparam int STEP_W = $clog2(STEP_PERIODS + 1);
  localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  phase_e              phase_q, phase_nxt;
  logic [PWM_BITS-1:0] duty_q, duty_nxt;
  logic [STEP_W-1:0]   step_cnt, step_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                tick;

  pwm_core #(.PWM_BITS(PWM_BITS)) u_pwm_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (phase_q != IDLE),
    .clear       (!en),
    .duty        (duty_q),
    .led_out     (led_out),
    .period_tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= IDLE;
      duty_q   <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      phase_q  <= phase_nxt;
      duty_q   <= duty_nxt;
      step_cnt <= step_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Disable wins over any step due on the same clock; duty only moves on a tick.
  always_comb begin
    phase_nxt = phase_q;
    duty_nxt  = duty_q;
    step_nxt  = step_cnt;
    hold_nxt  = hold_cnt;
    if (!en) begin
      phase_nxt = IDLE;
      duty_nxt  = '0;
      step_nxt  = '0;
      hold_nxt  = '0;
    end else begin
      case (phase_q)
        IDLE: phase_nxt = RAMP_UP;
        RAMP_UP: if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            duty_nxt = duty_q + PWM_BITS'(1);
            if (duty_q == DUTY_MAX - PWM_BITS'(1)) phase_nxt = HOLD_HI;
          end else begin
            step_nxt = step_cnt + STEP_W'(1);
          end
        end
        RAMP_DOWN: if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            duty_nxt = duty_q - PWM_BITS'(1);
            if (duty_q == PWM_BITS'(1)) phase_nxt = HOLD_LO;
          end else begin
            step_nxt = step_cnt + STEP_W'(1);
          end
        end
        HOLD_HI, HOLD_LO: if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_nxt  = '0;
            phase_nxt = (phase_q == HOLD_HI) ? RAMP_DOWN : RAMP_UP;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: phase_nxt = IDLE;
      endcase
    end
  end

  assign phase       = phase_q;
  assign duty        = duty_q;
  assign period_tick = tick;

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather with PWM_BITS=4, STEP_PERIODS=1, HOLD_PERIODS=2.
module tb_led_breather;

  localparam int PB = 4;

  typedef struct {
    int ph;
    int du;
    int hi;
    int len;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          led_out;
  logic          period_tick;
  logic [2:0]    phase;
  logic [PB-1:0] duty;

  int   errors = 0;
  int   checks = 0;
  int   mon_hi = 0;
  int   mon_len = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  led_breather #(.PWM_BITS(PB), .STEP_PERIODS(1), .HOLD_PERIODS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .led_out     (led_out),
    .phase       (phase),
    .duty        (duty),
    .period_tick (period_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected record for PWM period k counted from the enabling edge.
  // One breath = 15 ramp-up, 2 hold-high, 15 ramp-down, 2 hold-low periods.
  function automatic exp_t period_exp(input int k);
    exp_t e;
    int m;
    m = k % 34;
    if (m < 15)      begin e.ph = 1; e.du = m;      end
    else if (m < 17) begin e.ph = 2; e.du = 15;     end
    else if (m < 32) begin e.ph = 3; e.du = 32 - m; end
    else             begin e.ph = 4; e.du = 0;      end
    e.hi  = e.du;
    e.len = 16;
    return e;
  endfunction

  task automatic push_periods(input int first, input int count);
    for (int k = first; k < first + count; k++) q.push_back(period_exp(k));
  endtask

  // Monitor: one scoreboard entry per PWM period, checked on its period_tick.
  always @(negedge clk) begin
    exp_t e;
    if (phase == 3'd0) begin
      chk("idle_tick", int'(period_tick), 0);
      mon_hi  = 0;
      mon_len = 0;
    end else begin
      mon_len++;
      if (led_out) mon_hi++;
      if (period_tick) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got tick at phase %0d duty %0d, expected none", phase, duty);
        end else begin
          e = q.pop_front();
          chk("period_phase", int'(phase), e.ph);
          chk("period_duty", int'(duty), e.du);
          chk("period_led_high", mon_hi, e.hi);
          chk("period_length", mon_len, e.len);
        end
        mon_hi  = 0;
        mon_len = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_led", int'(led_out), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_tick", int'(period_tick), 0);

    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_phase", int'(phase), 0);
    chk("idle_led", int'(led_out), 0);

    // Full breath plus the start of the next one, then disable at duty 7.
    push_periods(0, 42);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start_phase", int'(phase), 1);
    chk("start_duty", int'(duty), 0);
    repeat (16 * 41 + 15) @(posedge clk);
    @(negedge clk);
    chk("drop_tick", int'(period_tick), 1);
    chk("drop_duty_before", int'(duty), 7);
    chk("drop_phase_before", int'(phase), 1);
    en = 1'b0;
    @(negedge clk);
    chk("drop_phase", int'(phase), 0);
    chk("drop_duty", int'(duty), 0);
    chk("drop_led", int'(led_out), 0);
    @(negedge clk);
    chk("drop_led_later", int'(led_out), 0);
    chk("breath_queue", q.size(), 0);

    // Re-enable, run into HOLD_HI, then assert reset between clock edges.
    push_periods(0, 16);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reen_phase", int'(phase), 1);
    chk("reen_duty", int'(duty), 0);
    repeat (16 * 16 + 4) @(posedge clk);
    #2;
    chk("hold_phase", int'(phase), 2);
    chk("hold_duty", int'(duty), 15);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("arst_phase", int'(phase), 0);
    chk("arst_duty", int'(duty), 0);
    chk("arst_led", int'(led_out), 0);
    chk("arst_tick", int'(period_tick), 0);
    chk("hold_queue", q.size(), 0);

    // Resume from IDLE after reset release.
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("resume_idle", int'(phase), 0);
    push_periods(0, 2);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("resume_phase", int'(phase), 1);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("final_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
